j1_stack_unit: RTL and testbench

//   Parametrised data/return stack for the J1 core family. Replaces the inline

---
 rtl/j1_stack_unit.sv | 108 ++++++++++
 tb/tb_j1_stack_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/j1_stack_unit.sv
// j1_stack_unit: parametrised J1 data/return stack with occupancy tracking,
// sticky overflow/underflow flags and a combinational PICK read port.
// Optional build macro: J1_STACK_GUARD_EN. When it is defined, any op that
// would overflow or underflow leaves sp, depth and memory untouched; the
// flags and the fault pulse are still raised so the core can trap.
module j1_stack_unit #(
    parameter int WIDTH     = 32,
    parameter int DEPTHBITS = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [1:0]           i_delta,
    input  logic                 i_we,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_top,
    input  logic [DEPTHBITS-1:0] i_pick_idx,
    output logic [WIDTH-1:0]     o_pick_data,
    output logic [DEPTHBITS-1:0] o_sp,
    output logic [DEPTHBITS:0]   o_depth,
    input  logic                 i_clr_flags,
    output logic                 o_ovf,
    output logic                 o_unf,
    output logic                 o_fault
);

    localparam int DEPTH = 2**DEPTHBITS;
    // Signed working width: holds depth (0..DEPTH) plus a step of -2..+1.
    localparam int NW    = DEPTHBITS + 3;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTHBITS-1:0] r_sp;
    logic [DEPTHBITS:0]   r_depth;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_fault;

    logic signed [NW-1:0] w_dn;
    logic signed [NW-1:0] w_nd;
    logic [DEPTHBITS-1:0] w_sp_n;
    logic [DEPTHBITS-1:0] w_pick_addr;
    logic [DEPTHBITS:0]   w_depth_n;
    logic                 w_ovf_ev;
    logic                 w_unf_ev;
    logic                 w_event;
    logic                 w_commit;

    // The 2-bit delta is a two's complement step: 00=0, 01=+1, 10=-2, 11=-1.
    assign w_dn     = {{(NW-2){i_delta[1]}}, i_delta};
    assign w_nd     = $signed({2'b00, r_depth}) + w_dn;
    assign w_sp_n   = r_sp + w_dn[DEPTHBITS-1:0];

    // Overwriting the top cell of an empty stack counts as an underflow.
    assign w_ovf_ev = (w_nd > $signed(NW'(DEPTH)));
    assign w_unf_ev = w_nd[NW-1] | ((i_delta == 2'b00) & i_we & (r_depth == '0));
    assign w_event  = w_ovf_ev | w_unf_ev;

`ifdef J1_STACK_GUARD_EN
    assign w_commit = ~w_event;
`else
    assign w_commit = 1'b1;
`endif

    // Next occupancy: saturate on events, otherwise follow the step.
    always_comb begin
        w_depth_n = w_nd[DEPTHBITS:0];
        if (w_ovf_ev)
            w_depth_n = (DEPTHBITS+1)'(DEPTH);
        else if (w_unf_ev)
            w_depth_n = '0;
    end

    // Storage: written at the new pointer, never cleared, blocked during reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_we && w_commit)
            r_mem[w_sp_n] <= i_wdata;
    end

    // Pointer, occupancy, sticky flags and the one-cycle fault pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sp    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (w_commit) begin
                r_sp    <= w_sp_n;
                r_depth <= w_depth_n;
            end
            // A new event beats a simultaneous clear.
            r_ovf   <= w_ovf_ev | (r_ovf & ~i_clr_flags);
            r_unf   <= w_unf_ev | (r_unf & ~i_clr_flags);
            r_fault <= w_event;
        end
    end

    assign w_pick_addr = r_sp - i_pick_idx;

    assign o_top       = r_mem[r_sp];
    assign o_pick_data = r_mem[w_pick_addr];
    assign o_sp        = r_sp;
    assign o_depth     = r_depth;
    assign o_ovf       = r_ovf;
    assign o_unf       = r_unf;
    assign o_fault     = r_fault;

endmodule

// File: tb/tb_j1_stack_unit.sv
// tb_j1_stack_unit: drives a 32x32 and a 16x8 stack with shared stimulus and
// compares both against an integer-arithmetic reference model after every edge.
module tb_j1_stack_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef J1_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        rst   = 1'b1;
    logic        we    = 1'b0;
    logic        clr   = 1'b0;
    logic [1:0]  delta = 2'b00;
    logic [31:0] wdata = '0;
    logic [4:0]  pick  = '0;

    logic [31:0] a_top, a_pick;
    logic [4:0]  a_sp;
    logic [5:0]  a_depth;
    logic        a_ovf, a_unf, a_fault;
    logic [15:0] b_top, b_pick;
    logic [2:0]  b_sp;
    logic [3:0]  b_depth;
    logic        b_ovf, b_unf, b_fault;

    j1_stack_unit #(.WIDTH(32), .DEPTHBITS(5)) u_a (
        .i_clk(clk), .i_reset(rst), .i_delta(delta), .i_we(we), .i_wdata(wdata),
        .o_top(a_top), .i_pick_idx(pick), .o_pick_data(a_pick), .o_sp(a_sp),
        .o_depth(a_depth), .i_clr_flags(clr), .o_ovf(a_ovf), .o_unf(a_unf),
        .o_fault(a_fault)
    );

    j1_stack_unit #(.WIDTH(16), .DEPTHBITS(3)) u_b (
        .i_clk(clk), .i_reset(rst), .i_delta(delta), .i_we(we), .i_wdata(wdata[15:0]),
        .o_top(b_top), .i_pick_idx(pick[2:0]), .o_pick_data(b_pick), .o_sp(b_sp),
        .o_depth(b_depth), .i_clr_flags(clr), .o_ovf(b_ovf), .o_unf(b_unf),
        .o_fault(b_fault)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: index 0 = 32-deep/32-bit, index 1 = 8-deep/16-bit.
    int          DEP [2] = '{32, 8};
    logic [31:0] MSK [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] m_mem [2][32];
    bit          m_val [2][32];
    int          m_sp [2]    = '{0, 0};
    int          m_depth [2] = '{0, 0};
    bit          m_ovf [2]   = '{0, 0};
    bit          m_unf [2]   = '{0, 0};
    bit          m_fault [2] = '{0, 0};

    function automatic int wrap(input int v, input int d);
        return ((v % d) + d) % d;
    endfunction

    task automatic step(input int k);
        int d, dn, nd, spn;
        bit ov, un, ev;
        d = DEP[k];
        if (rst) begin
            m_sp[k] = 0; m_depth[k] = 0;
            m_ovf[k] = 0; m_unf[k] = 0; m_fault[k] = 0;
            return;
        end
        case (delta)
            2'b01:   dn = 1;
            2'b10:   dn = -2;
            2'b11:   dn = -1;
            default: dn = 0;
        endcase
        nd = m_depth[k] + dn;
        ov = nd > d;
        un = (nd < 0) || (delta == 2'b00 && we && m_depth[k] == 0);
        ev = ov || un;
        if (!(GUARD && ev)) begin
            spn = wrap(m_sp[k] + dn, d);
            if (we) begin
                m_mem[k][spn] = wdata & MSK[k];
                m_val[k][spn] = 1'b1;
            end
            m_sp[k]    = spn;
            m_depth[k] = ov ? d : (un ? 0 : nd);
        end
        m_ovf[k]   = ov || (m_ovf[k] && !clr);
        m_unf[k]   = un || (m_unf[k] && !clr);
        m_fault[k] = ev;
    endtask

    task automatic verify();
        int pa, pb;
        pa = wrap(m_sp[0] - int'(pick), 32);
        pb = wrap(m_sp[1] - int'(pick[2:0]), 8);
        check("a.sp",    a_sp,    m_sp[0]);
        check("a.depth", a_depth, m_depth[0]);
        check("a.ovf",   a_ovf,   m_ovf[0]);
        check("a.unf",   a_unf,   m_unf[0]);
        check("a.fault", a_fault, m_fault[0]);
        if (m_val[0][m_sp[0]]) check("a.top",  a_top,  m_mem[0][m_sp[0]]);
        if (m_val[0][pa])      check("a.pick", a_pick, m_mem[0][pa]);
        check("b.sp",    b_sp,    m_sp[1]);
        check("b.depth", b_depth, m_depth[1]);
        check("b.ovf",   b_ovf,   m_ovf[1]);
        check("b.unf",   b_unf,   m_unf[1]);
        check("b.fault", b_fault, m_fault[1]);
        if (m_val[1][m_sp[1]]) check("b.top",  b_top,  m_mem[1][m_sp[1]]);
        if (m_val[1][pb])      check("b.pick", b_pick, m_mem[1][pb]);
    endtask

    // One clock: drive inputs, advance the model on the edge, sample 1ns later.
    task automatic cyc(input bit r, input logic [1:0] dl, input bit w,
                       input logic [31:0] wd, input bit c, input logic [4:0] p);
        rst = r; delta = dl; we = w; wdata = wd; clr = c; pick = p;
        @(posedge clk);
        step(0);
        step(1);
        #1;
        verify();
    endtask

    initial begin
        // Reset state
        cyc(1, 2'b00, 0, 0, 0, 0);
        cyc(1, 2'b00, 0, 0, 0, 0);
        check("rst.sp", a_sp, 0);
        check("rst.depth", a_depth, 0);
        check("rst.flags", {a_ovf, a_unf, a_fault}, 0);

        // Three pushes, then a deep pick
        cyc(0, 2'b01, 1, 32'hA, 0, 0);
        cyc(0, 2'b01, 1, 32'hB, 0, 0);
        cyc(0, 2'b01, 1, 32'hC, 0, 2);
        check("t1.top", a_top, 32'hC);
        check("t1.depth", a_depth, 3);
        check("t1.sp", a_sp, 3);
        check("t1.pick2", a_pick, 32'hA);
        check("t1.b.top", b_top, 16'hC);
        check("t1.b.pick2", b_pick, 16'hA);

        // Drop two, drop one, then underflow
        cyc(0, 2'b10, 0, 0, 0, 0);
        check("t2.top", a_top, 32'hA);
        check("t2.depth", a_depth, 1);
        cyc(0, 2'b11, 0, 0, 0, 0);
        check("t2.depth0", a_depth, 0);
        check("t2.unf0", a_unf, 0);
        cyc(0, 2'b11, 0, 0, 0, 0);
        check("t2.unf1", a_unf, 1);
        check("t2.fault", a_fault, 1);
        check("t2.depth", a_depth, 0);
        check("t2.sp", a_sp, GUARD ? 5'd0 : 5'd31);
        check("t2.b.sp", b_sp, GUARD ? 3'd0 : 3'd7);
        cyc(0, 2'b00, 0, 0, 0, 0);
        check("t2.fault_pulse", a_fault, 0);
        check("t2.unf_sticky", a_unf, 1);

        // Fill to capacity then overflow
        cyc(1, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) cyc(0, 2'b01, 1, i, 0, 0);
        check("t3.depth", a_depth, 32);
        check("t3.ovf0", a_ovf, 0);
        check("t3.b.depth", b_depth, 8);
        check("t3.b.ovf", b_ovf, 1);
        cyc(0, 2'b01, 1, 32'h99, 0, 0);
        check("t3.ovf1", a_ovf, 1);
        check("t3.fault", a_fault, 1);
        check("t3.depth32", a_depth, 32);
        check("t3.top", a_top, GUARD ? 32'd31 : 32'h99);
        check("t3.sp", a_sp, GUARD ? 5'd0 : 5'd1);

        // Clear racing a new overflow, then a lone clear
        cyc(0, 2'b01, 1, 32'h77, 1, 0);
        check("t4.ovf_wins", a_ovf, 1);
        cyc(0, 2'b00, 0, 0, 1, 0);
        check("t4.clr_ovf", a_ovf, 0);
        check("t4.clr_unf", a_unf, 0);

        // Reset while pushing: the write must not land
        cyc(0, 2'b01, 1, 32'h11, 0, 0);
        cyc(0, 2'b01, 1, 32'h22, 0, 0);
        cyc(1, 2'b01, 1, 32'h55, 0, 0);
        check("t5.sp", a_sp, 0);
        check("t5.depth", a_depth, 0);
        check("t5.flags", {a_ovf, a_unf, a_fault}, 0);
        cyc(0, 2'b01, 0, 0, 0, 0);
        check("t5.nocommit", a_top == 32'h55, 0);

        // Randomised traffic, biased slightly toward pushes
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] dl;
            r = $urandom_range(0, 7);
            dl = (r < 4) ? 2'b01 : (r == 4) ? 2'b00 : (r == 5) ? 2'b10 : 2'b11;
            cyc(($urandom_range(0, 63) == 0), dl, $urandom_range(0, 1), $urandom,
                ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
